// File: rtl/mdio_master_pkg.sv
// Shared MDIO Clause-22 constants, FSM state type and frame builder.
package mdio_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_TA,
    ST_DATA,
    ST_GAP
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam int unsigned HDR_BITS  = 14;
  localparam int unsigned TA_BITS   = 2;
  localparam int unsigned DATA_BITS = 16;

  // Everything after the preamble as one MSB-first word; read TA/data are
  // all ones so the shifter naturally leaves MDIO released-high.
  function automatic logic [31:0] build_frame(input logic       write,
                                              input logic [4:0] phyad,
                                              input logic [4:0] regad,
                                              input logic [15:0] wdata);
    return {MDIO_ST,
            write ? MDIO_OP_WR : MDIO_OP_RD,
            phyad,
            regad,
            write ? 2'b10 : 2'b11,
            write ? wdata : 16'hFFFF};
  endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// MDC divider: low for CLK_DIV cycles then high for CLK_DIV cycles, with
// strobes on the edges that start a low phase and that raise MDC.
module mdc_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk_50,
  input  logic reset_i,
  input  logic run,
  input  logic mdc_en,
  output logic mdc_o,
  output logic mdc_fall_stb,
  output logic mdc_rise_stb
);

  localparam int unsigned CW = $clog2(2 * CLK_DIV);

  logic [CW-1:0] cnt;

  assign mdc_rise_stb = run && (cnt == CW'(CLK_DIV - 1));
  assign mdc_fall_stb = run && (cnt == CW'(2 * CLK_DIV - 1));

  // Holding the counter at zero while idle keeps every frame phase-aligned.
  always_ff @(posedge clk_50) begin
    if (reset_i || !run) begin
      cnt   <= '0;
      mdc_o <= 1'b0;
    end else begin
      cnt <= mdc_fall_stb ? '0 : cnt + CW'(1);
      if (mdc_rise_stb)
        mdc_o <= mdc_en;
      else if (mdc_fall_stb)
        mdc_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: accepts one read/write command at a time, runs
// preamble/header/turnaround/data, then an idle gap before the next command.
module mdio_master
  import mdio_master_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned PREAMBLE_BITS = 32,
  parameter int unsigned IDLE_BITS     = 1
) (
  input  logic        clk_50,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic        cmd_pre_sup_i,
  input  logic [4:0]  cmd_phy_addr_i,
  input  logic [4:0]  cmd_reg_addr_i,
  input  logic [15:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_ta_error_o,
  output logic        busy_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  mdio_state_e state, state_n;
  logic [15:0] bit_cnt, bit_cnt_n;
  logic [31:0] tx, tx_n;
  logic [15:0] rx, rx_n;
  logic        is_wr, is_wr_n;
  logic        ta_err, ta_err_n;
  logic        mdio_q, mdio_n;
  logic        oe_q, oe_n;
  logic        ready_q, ready_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [15:0] rsp_rdata_q, rsp_rdata_n;
  logic        rsp_ta_q, rsp_ta_n;
  logic [31:0] frame;
  logic        fall_stb, rise_stb;

  mdc_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_mdc_gen (
    .clk_50      (clk_50),
    .reset_i     (reset_i),
    .run         (state != ST_IDLE),
    .mdc_en      (state != ST_GAP),
    .mdc_o       (mdc_o),
    .mdc_fall_stb(fall_stb),
    .mdc_rise_stb(rise_stb)
  );

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    tx_n        = tx;
    rx_n        = rx;
    is_wr_n     = is_wr;
    ta_err_n    = ta_err;
    mdio_n      = mdio_q;
    oe_n        = oe_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata_q;
    rsp_ta_n    = rsp_ta_q;
    frame       = build_frame(cmd_write_i, cmd_phy_addr_i, cmd_reg_addr_i, cmd_wdata_i);

    case (state)
      ST_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          is_wr_n  = cmd_write_i;
          ta_err_n = 1'b0;
          rx_n     = '0;
          oe_n     = 1'b1;
          if (cmd_pre_sup_i) begin
            state_n   = ST_HDR;
            bit_cnt_n = 16'(HDR_BITS - 1);
            mdio_n    = frame[31];
            tx_n      = {frame[30:0], 1'b0};
          end else begin
            state_n   = ST_PRE;
            bit_cnt_n = 16'(PREAMBLE_BITS - 1);
            mdio_n    = 1'b1;
            tx_n      = frame;
          end
        end
      end

      ST_PRE: begin
        if (fall_stb) begin
          if (bit_cnt == '0) begin
            state_n   = ST_HDR;
            bit_cnt_n = 16'(HDR_BITS - 1);
            mdio_n    = tx[31];
            tx_n      = {tx[30:0], 1'b0};
          end else begin
            bit_cnt_n = bit_cnt - 16'd1;
          end
        end
      end

      ST_HDR: begin
        if (fall_stb) begin
          mdio_n = tx[31];
          tx_n   = {tx[30:0], 1'b0};
          if (bit_cnt == '0) begin
            state_n   = ST_TA;
            bit_cnt_n = 16'(TA_BITS - 1);
            oe_n      = is_wr;
          end else begin
            bit_cnt_n = bit_cnt - 16'd1;
          end
        end
      end

      ST_TA: begin
        if (rise_stb && bit_cnt == '0)
          ta_err_n = mdio_i;
        if (fall_stb) begin
          mdio_n = tx[31];
          tx_n   = {tx[30:0], 1'b0};
          if (bit_cnt == '0) begin
            state_n   = ST_DATA;
            bit_cnt_n = 16'(DATA_BITS - 1);
          end else begin
            bit_cnt_n = bit_cnt - 16'd1;
          end
        end
      end

      ST_DATA: begin
        if (rise_stb)
          rx_n = {rx[14:0], mdio_i};
        if (fall_stb) begin
          if (bit_cnt == '0) begin
            state_n     = ST_GAP;
            bit_cnt_n   = 16'(IDLE_BITS - 1);
            oe_n        = 1'b0;
            mdio_n      = 1'b1;
            rsp_valid_n = 1'b1;
            rsp_rdata_n = is_wr ? 16'h0000 : rx;
            rsp_ta_n    = !is_wr && ta_err;
          end else begin
            mdio_n    = tx[31];
            tx_n      = {tx[30:0], 1'b0};
            bit_cnt_n = bit_cnt - 16'd1;
          end
        end
      end

      ST_GAP: begin
        if (fall_stb) begin
          if (bit_cnt == '0)
            state_n = ST_IDLE;
          else
            bit_cnt_n = bit_cnt - 16'd1;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_IDLE);
  end

  always_ff @(posedge clk_50) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      tx          <= '0;
      rx          <= '0;
      is_wr       <= 1'b0;
      ta_err      <= 1'b0;
      mdio_q      <= 1'b1;
      oe_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_ta_q    <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      tx          <= tx_n;
      rx          <= rx_n;
      is_wr       <= is_wr_n;
      ta_err      <= ta_err_n;
      mdio_q      <= mdio_n;
      oe_q        <= oe_n;
      ready_q     <= ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_ta_q    <= rsp_ta_n;
    end
  end

  assign cmd_ready_o    = ready_q;
  assign busy_o         = (state != ST_IDLE);
  assign mdio_o         = mdio_q;
  assign mdio_oe_o      = oe_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_ta_error_o = rsp_ta_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed + randomized MDIO frames checked against a bit-level frame model.
module tb_mdio_master;

  localparam int unsigned CD = 2;
  localparam int unsigned PB = 32;
  localparam int unsigned IB = 1;

  logic        clk_50 = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic        cmd_pre_sup_i = 1'b0;
  logic [4:0]  cmd_phy_addr_i = '0;
  logic [4:0]  cmd_reg_addr_i = '0;
  logic [15:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic [15:0] rsp_rdata_o;
  logic        rsp_ta_error_o;
  logic        busy_o;
  logic        mdc_o;
  logic        mdio_o;
  logic        mdio_oe_o;
  logic        mdio_i = 1'b1;

  int passed = 0;
  int total  = 0;

  always #5 clk_50 = ~clk_50;

  mdio_master #(
    .CLK_DIV      (CD),
    .PREAMBLE_BITS(PB),
    .IDLE_BITS    (IB)
  ) dut (
    .clk_50        (clk_50),
    .reset_i       (reset_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_write_i   (cmd_write_i),
    .cmd_pre_sup_i (cmd_pre_sup_i),
    .cmd_phy_addr_i(cmd_phy_addr_i),
    .cmd_reg_addr_i(cmd_reg_addr_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_ta_error_o(rsp_ta_error_o),
    .busy_o        (busy_o),
    .mdc_o         (mdc_o),
    .mdio_o        (mdio_o),
    .mdio_oe_o     (mdio_oe_o),
    .mdio_i        (mdio_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command from accept to ready, with a PHY model on mdio_i. When
  // abort_bit >= 0, reset is asserted right after that bit's MDC rise.
  task automatic run_cmd(input logic wr, input logic ps, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd,
                         input logic present, input logic [15:0] rd,
                         input int abort_bit);
    bit   eb[$];
    bit   eo[$];
    bit   ob[$];
    bit   oo[$];
    int   nb, npre, idx, rises = 0, rsp_cyc = -1, rdy_cyc = -1;
    int   pulses = 0, viol = 0, dmis = 0, omis = 0;
    logic [15:0] got_rd = '0;
    logic        got_ta = 1'b0;
    logic        prev_mdc = 1'b0, prev_mdio = 1'b1, prev_oe = 1'b0, v;
    logic [15:0] exp_rd;
    logic        exp_ta;

    npre = ps ? 0 : PB;
    for (int i = 0; i < npre; i++) begin eb.push_back(1); eo.push_back(1); end
    eb.push_back(0); eb.push_back(1);
    eb.push_back(!wr); eb.push_back(wr);
    for (int i = 4; i >= 0; i--) eb.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) eb.push_back(ra[i]);
    repeat (14) eo.push_back(1);
    eb.push_back(1); eb.push_back(0);
    eo.push_back(wr); eo.push_back(wr);
    for (int i = 15; i >= 0; i--) begin eb.push_back(wd[i]); eo.push_back(wr); end
    nb = eb.size();

    @(negedge clk_50);
    cmd_write_i = wr; cmd_pre_sup_i = ps; cmd_phy_addr_i = pa;
    cmd_reg_addr_i = ra; cmd_wdata_i = wd; cmd_valid_i = 1'b1;
    chk("ready_before_accept", cmd_ready_o, 1);
    @(posedge clk_50);
    @(negedge clk_50);
    cmd_valid_i = 1'b0;
    chk("ready_drop", cmd_ready_o, 0);
    chk("busy_rise", busy_o, 1);

    for (int c = 1; c <= nb * 2 * CD + IB * 2 * CD + 40; c++) begin
      if (c > 1) @(negedge clk_50);
      if (((c - 1) % (2 * CD)) != 0 && (mdio_o !== prev_mdio || mdio_oe_o !== prev_oe)) viol++;
      if (rsp_cyc >= 0 && mdc_o !== 1'b0) viol++;
      if (mdc_o === 1'b1 && prev_mdc === 1'b0) begin
        if (c != 1 + rises * 2 * CD + CD) viol++;
        ob.push_back(mdio_o); oo.push_back(mdio_oe_o);
        rises++;
        idx = rises - npre;
        v = 1'b1;
        if (!wr && present) begin
          if (idx == 15) v = 1'b0;
          else if (idx >= 16 && idx < 32) v = rd[31 - idx];
        end
        mdio_i = v;
      end
      if (rsp_valid_o === 1'b1) begin
        pulses++;
        if (rsp_cyc < 0) begin rsp_cyc = c; got_rd = rsp_rdata_o; got_ta = rsp_ta_error_o; end
      end
      if (c == 20) begin
        cmd_valid_i = 1'b1; cmd_write_i = !wr; cmd_pre_sup_i = !ps; cmd_phy_addr_i = ~pa;
      end
      if (c == 21) cmd_valid_i = 1'b0;
      if (abort_bit >= 0 && rises == abort_bit + 1) begin
        reset_i = 1'b1;
        @(posedge clk_50);
        @(negedge clk_50);
        reset_i = 1'b0;
        mdio_i = 1'b1;
        chk("abort_mdc", mdc_o, 0);
        chk("abort_oe", mdio_oe_o, 0);
        chk("abort_mdio", mdio_o, 1);
        chk("abort_rsp_rdata", rsp_rdata_o, 0);
        chk("abort_busy", busy_o, 0);
        repeat (30) begin
          if (rsp_valid_o === 1'b1) pulses++;
          @(negedge clk_50);
        end
        chk("abort_no_rsp", pulses, 0);
        return;
      end
      if (cmd_ready_o === 1'b1) begin
        rdy_cyc = c;
        chk("busy_fall_with_ready", busy_o, 0);
        break;
      end
      prev_mdc = mdc_o; prev_mdio = mdio_o; prev_oe = mdio_oe_o;
    end
    mdio_i = 1'b1;

    for (int i = 0; i < nb; i++) begin
      if (i >= ob.size()) begin dmis++; omis++; end
      else begin
        if (eo[i] && ob[i] != eb[i]) dmis++;
        if (oo[i] != eo[i]) omis++;
      end
    end
    exp_rd = wr ? 16'h0000 : (present ? rd : 16'hFFFF);
    exp_ta = !wr && !present;

    chk("mdc_rises", rises, nb);
    chk("mdio_stream_mismatches", dmis, 0);
    chk("oe_pattern_mismatches", omis, 0);
    chk("rsp_cycle", rsp_cyc, 1 + nb * 2 * CD);
    chk("rsp_pulses", pulses, 1);
    chk("rsp_rdata", got_rd, exp_rd);
    chk("rsp_ta_error", got_ta, exp_ta);
    chk("ready_cycle", rdy_cyc, 1 + nb * 2 * CD + IB * 2 * CD);
    chk("timing_violations", viol, 0);
  endtask

  initial begin
    logic [4:0]  pa, ra;
    logic [15:0] wd, rd;

    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_ta_error", rsp_ta_error_o, 0);
    chk("rst_mdc", mdc_o, 0);
    chk("rst_mdio", mdio_o, 1);
    chk("rst_oe", mdio_oe_o, 0);
    reset_i = 1'b0;
    @(posedge clk_50);
    @(negedge clk_50);
    chk("ready_after_release", cmd_ready_o, 1);
    chk("mdc_idle_low", mdc_o, 0);

    run_cmd(1'b1, 1'b0, 5'h01, 5'h00, 16'h1140, 1'b1, 16'h0000, -1);
    run_cmd(1'b0, 1'b0, 5'h02, 5'h02, 16'h0000, 1'b1, 16'h0141, -1);
    run_cmd(1'b0, 1'b0, 5'h03, 5'h01, 16'h0000, 1'b0, 16'h0000, -1);

    pa = 5'($urandom); ra = 5'($urandom); rd = 16'($urandom);
    run_cmd(1'b0, 1'b1, pa, ra, 16'h0000, 1'b1, rd, -1);

    for (int n = 0; n < 4; n++) begin
      pa = 5'($urandom); ra = 5'($urandom); wd = 16'($urandom); rd = 16'($urandom);
      run_cmd(1'($urandom), 1'($urandom), pa, ra, wd, 1'($urandom_range(0, 3) != 0), rd, -1);
    end

    wd = 16'($urandom);
    run_cmd(1'b1, 1'b0, 5'h04, 5'h09, wd, 1'b1, 16'h0000, int'(PB) + 14 + 2 + 5);
    @(negedge clk_50);
    rd = 16'($urandom);
    run_cmd(1'b0, 1'b0, 5'h04, 5'h09, 16'h0000, 1'b1, rd, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
